// File: rtl/stdp_pair_scheduler.sv
// STDP pair scheduler: stamps spikes per timestep, then walks LTP/LTD pairs through the dw datapath.
// Define STDP_WINDOW_EN to skip pairs whose |t_pre - t_post| exceeds WINDOW.
module stdp_pair_scheduler #(
    parameter int NUM_PRE  = 4,
    parameter int NUM_POST = 4,
    parameter int N        = 32,
    parameter int FRAC     = 16,
    parameter int TS_W     = 8,
    parameter int WINDOW   = 4,
    localparam int AW = (NUM_PRE * NUM_POST > 1) ? $clog2(NUM_PRE * NUM_POST) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    output logic                step_ready,
    input  logic [NUM_PRE-1:0]  pre_spike,
    input  logic [NUM_POST-1:0] post_spike,
    output logic [N-1:0]        t_change,
    output logic                apply,
    input  logic [N-1:0]        dw_in,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [AW-1:0]       upd_addr,
    output logic [N-1:0]        upd_dw,
    output logic                done,
    output logic                overrun
);
    localparam int PW = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1;
    localparam int QW = (NUM_POST > 1) ? $clog2(NUM_POST) : 1;
    localparam int MW = N - 1 - FRAC;
    localparam int XW = (TS_W > MW) ? TS_W : MW;
`ifdef STDP_WINDOW_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_CAPTURE, S_WAIT} state_t;
    state_t state, state_nxt;

    logic [TS_W-1:0]     time_now;
    logic [TS_W-1:0]     last_pre [NUM_PRE];
    logic [TS_W-1:0]     last_post [NUM_POST];
    logic [NUM_PRE-1:0]  pre_ok, pre_lat;
    logic [NUM_POST-1:0] post_ok, post_lat;
    logic                phase_d, active;
    logic [PW-1:0]       i_idx;
    logic [QW-1:0]       j_idx;

    logic [TS_W-1:0] diff, mag;
    logic [XW-1:0]   mag_x;
    logic [MW-1:0]   mag_sat;
    logic            in_window, qualify;

    always_comb begin
        diff      = last_pre[i_idx] - last_post[j_idx];
        mag       = diff[TS_W-1] ? (-diff) : diff;
        mag_x     = XW'(mag);
        mag_sat   = (mag_x > XW'({MW{1'b1}})) ? '1 : mag_x[MW-1:0];
        in_window = !(WIN_EN && (int'(mag) > WINDOW));
        qualify   = pre_ok[i_idx] && post_ok[j_idx] && (diff != '0) && in_window;
    end

    // lowest set index search; descending loops let the lowest hit win
    logic          first_pre_hit, nxt_pre_hit, nxt_post_hit;
    logic [PW-1:0] first_pre, nxt_pre, in_pre;
    logic [QW-1:0] nxt_post, in_post;

    always_comb begin
        first_pre_hit = 1'b0;
        nxt_pre_hit   = 1'b0;
        nxt_post_hit  = 1'b0;
        first_pre     = '0;
        nxt_pre       = '0;
        in_pre        = '0;
        nxt_post      = '0;
        in_post       = '0;
        for (int k = NUM_PRE - 1; k >= 0; k--) begin
            if (pre_lat[k]) begin
                first_pre_hit = 1'b1;
                first_pre     = PW'(k);
            end
            if (pre_lat[k] && k > int'(i_idx)) begin
                nxt_pre_hit = 1'b1;
                nxt_pre     = PW'(k);
            end
            if (pre_spike[k]) in_pre = PW'(k);
        end
        for (int k = NUM_POST - 1; k >= 0; k--) begin
            if (post_lat[k] && k > int'(j_idx)) begin
                nxt_post_hit = 1'b1;
                nxt_post     = QW'(k);
            end
            if (post_spike[k]) in_post = QW'(k);
        end
    end

    logic          adv_end, adv_phase_d;
    logic [PW-1:0] adv_i;
    logic [QW-1:0] adv_j;

    always_comb begin
        adv_end     = 1'b0;
        adv_phase_d = phase_d;
        adv_i       = i_idx;
        adv_j       = j_idx;
        if (!phase_d) begin
            if (int'(i_idx) < NUM_PRE - 1) begin
                adv_i = i_idx + PW'(1);
            end else if (nxt_post_hit) begin
                adv_j = nxt_post;
                adv_i = '0;
            end else if (first_pre_hit) begin
                adv_phase_d = 1'b1;
                adv_i       = first_pre;
                adv_j       = '0;
            end else begin
                adv_end = 1'b1;
            end
        end else begin
            if (int'(j_idx) < NUM_POST - 1) begin
                adv_j = j_idx + QW'(1);
            end else if (nxt_pre_hit) begin
                adv_i = nxt_pre;
                adv_j = '0;
            end else begin
                adv_end = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        step_ready = (state == S_IDLE);
        apply      = (state == S_ISSUE) || (state == S_CAPTURE);
        unique case (state)
            S_IDLE:    if (step) state_nxt = S_SCAN;
            S_SCAN: begin
                if (!active)      state_nxt = S_IDLE;
                else if (qualify) state_nxt = S_ISSUE;
                else if (adv_end) state_nxt = S_IDLE;
            end
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_WAIT;
            S_WAIT:    if (upd_ready) state_nxt = S_SCAN;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_now  <= '0;
            pre_ok    <= '0;
            post_ok   <= '0;
            pre_lat   <= '0;
            post_lat  <= '0;
            phase_d   <= 1'b0;
            active    <= 1'b0;
            i_idx     <= '0;
            j_idx     <= '0;
            t_change  <= '0;
            upd_valid <= 1'b0;
            upd_addr  <= '0;
            upd_dw    <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < NUM_PRE; k++)  last_pre[k]  <= '0;
            for (int k = 0; k < NUM_POST; k++) last_post[k] <= '0;
        end else begin
            done <= 1'b0;
            if (step && state != S_IDLE) overrun <= 1'b1;
            case (state)
                S_IDLE: if (step) begin
                    pre_lat  <= pre_spike;
                    post_lat <= post_spike;
                    for (int k = 0; k < NUM_PRE; k++) begin
                        if (pre_spike[k]) begin
                            last_pre[k] <= time_now;
                            pre_ok[k]   <= 1'b1;
                        end
                    end
                    for (int k = 0; k < NUM_POST; k++) begin
                        if (post_spike[k]) begin
                            last_post[k] <= time_now;
                            post_ok[k]   <= 1'b1;
                        end
                    end
                    time_now <= time_now + TS_W'(1);
                    phase_d  <= ~|post_spike;
                    i_idx    <= (|post_spike) ? '0 : in_pre;
                    j_idx    <= (|post_spike) ? in_post : '0;
                    active   <= (|post_spike) || (|pre_spike);
                end
                S_SCAN: begin
                    if (!active) begin
                        done <= 1'b1;
                    end else if (qualify) begin
                        t_change <= {diff[TS_W-1], mag_sat, {FRAC{1'b0}}};
                    end else if (adv_end) begin
                        done   <= 1'b1;
                        active <= 1'b0;
                    end else begin
                        phase_d <= adv_phase_d;
                        i_idx   <= adv_i;
                        j_idx   <= adv_j;
                    end
                end
                S_CAPTURE: begin
                    upd_dw    <= dw_in;
                    upd_addr  <= AW'(int'(i_idx) * NUM_POST + int'(j_idx));
                    upd_valid <= 1'b1;
                end
                S_WAIT: if (upd_ready) begin
                    upd_valid <= 1'b0;
                    if (adv_end) begin
                        active <= 1'b0;
                    end else begin
                        phase_d <= adv_phase_d;
                        i_idx   <= adv_i;
                        j_idx   <= adv_j;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stdp_pair_scheduler.sv
// Scoreboard bench for stdp_pair_scheduler: directed spike steps, monitor checks each weight update.
// Honors STDP_WINDOW_EN for the wrap-around window case.
module tb_stdp_pair_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic        step_ready;
    logic [3:0]  pre_spike;
    logic [3:0]  post_spike;
    logic [31:0] t_change;
    logic        apply;
    logic [31:0] dw_in;
    logic        upd_valid;
    logic        upd_ready;
    logic [3:0]  upd_addr;
    logic [31:0] upd_dw;
    logic        done;
    logic        overrun;

    always #5 clk = ~clk;

    stdp_pair_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .step_ready (step_ready),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .t_change   (t_change),
        .apply      (apply),
        .dw_in      (dw_in),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_addr   (upd_addr),
        .upd_dw     (upd_dw),
        .done       (done),
        .overrun    (overrun)
    );

    // stand-in datapath: dw is a keyed copy of t_change while apply is high
    localparam logic [31:0] DW_KEY = 32'h0000_A5A5;
    assign dw_in = apply ? (t_change ^ DW_KEY) : 32'hDEAD_BEEF;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] t;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   ap_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] addr, input logic [31:0] t);
        exp_t e;
        e.addr = addr;
        e.t    = t;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            ap_cnt = 0;
        end else begin
            if (apply) begin
                ap_cnt++;
            end else if (ap_cnt != 0) begin
                chk("apply_len", 32'(ap_cnt), 32'd2);
                ap_cnt = 0;
            end
            if (upd_valid && upd_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: actual addr=%0d t=%h required no update",
                             upd_addr, t_change);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("upd_addr", 32'(upd_addr), 32'(mon_e.addr));
                    chk("t_change", t_change, mon_e.t);
                    chk("upd_dw", upd_dw, mon_e.t ^ DW_KEY);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        chk("done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(input logic [3:0] pre, input logic [3:0] post, input bit wait_d);
        int n = 0;
        while (!step_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("step_ready", 32'(step_ready), 32'd1);
        step       = 1'b1;
        pre_spike  = pre;
        post_spike = post;
        @(posedge clk);
        #1;
        step       = 1'b0;
        pre_spike  = '0;
        post_spike = '0;
        if (wait_d) wait_done();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!upd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("upd_valid_seen", 32'(upd_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        step       = 1'b0;
        pre_spike  = '0;
        post_spike = '0;
        upd_ready  = 1'b1;
        do_reset();
        chk("rst_step_ready", 32'(step_ready), 32'd1);
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_apply", 32'(apply), 32'd0);
        chk("rst_t_change", t_change, 32'd0);
        chk("rst_upd_addr", 32'(upd_addr), 32'd0);
        chk("rst_upd_dw", upd_dw, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // LTP: pre0 @3, post0 @5 -> diff -2
        repeat (3) do_step(4'h0, 4'h0, 1'b1);
        do_step(4'b0001, 4'h0, 1'b1);
        do_step(4'h0, 4'h0, 1'b1);
        push(4'd0, 32'h8002_0000);
        do_step(4'h0, 4'b0001, 1'b1);
        chk("sb_empty_ltp", 32'(sbq.size()), 32'd0);

        // simultaneous pre0/post0 @6 -> diff 0, nothing issued
        do_step(4'b0001, 4'b0001, 1'b1);
        chk("t_change_held", t_change, 32'h8002_0000);
        chk("no_valid_simul", 32'(upd_valid), 32'd0);

        // LTD: post1 @2, pre2 @3 -> diff +1, addr 9
        do_reset();
        repeat (2) do_step(4'h0, 4'h0, 1'b1);
        do_step(4'h0, 4'b0010, 1'b1);
        push(4'd9, 32'h0001_0000);
        do_step(4'b0100, 4'h0, 1'b1);
        chk("sb_empty_ltd", 32'(sbq.size()), 32'd0);

        // backpressure: two LTP pairs, store stalls on the first
        do_reset();
        upd_ready = 1'b0;
        do_step(4'b0011, 4'h0, 1'b1);
        push(4'd2, 32'h8001_0000);
        push(4'd6, 32'h8001_0000);
        do_step(4'h0, 4'b0100, 1'b0);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 32'(upd_valid), 32'd1);
            chk("hold_addr", 32'(upd_addr), 32'd2);
            chk("hold_dw", upd_dw, 32'h8001_0000 ^ DW_KEY);
            chk("hold_no_apply", 32'(apply), 32'd0);
        end
        @(posedge clk);
        #1;
        upd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("adv_scan_apply", 32'(apply), 32'd0);
        @(negedge clk);
        chk("adv_issue_apply", 32'(apply), 32'd1);
        wait_done();
        chk("sb_empty_bp", 32'(sbq.size()), 32'd0);

        // step during SCAN is ignored and time does not advance
        do_reset();
        chk("overrun_clear", 32'(overrun), 32'd0);
        do_step(4'b0001, 4'h0, 1'b0);
        step       = 1'b1;
        post_spike = 4'b0001;
        @(posedge clk);
        #1;
        step       = 1'b0;
        post_spike = '0;
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_done();
        push(4'd0, 32'h8001_0000);
        do_step(4'h0, 4'b0001, 1'b1);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        chk("sb_empty_ovr", 32'(sbq.size()), 32'd0);

        // reset while an update is stalled in WAIT
        upd_ready = 1'b0;
        push(4'd4, 32'h0001_0000);
        do_step(4'b0010, 4'h0, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rstw_upd_valid", 32'(upd_valid), 32'd0);
        chk("rstw_step_ready", 32'(step_ready), 32'd1);
        chk("rstw_overrun", 32'(overrun), 32'd0);
        upd_ready = 1'b1;

        // timestamp wrap: pre0 @250, post0 @0 -> diff -6
        do_reset();
        repeat (250) do_step(4'h0, 4'h0, 1'b1);
        do_step(4'b0001, 4'h0, 1'b1);
        repeat (5) do_step(4'h0, 4'h0, 1'b1);
`ifndef STDP_WINDOW_EN
        push(4'd0, 32'h8006_0000);
`endif
        do_step(4'h0, 4'b0001, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty_wrap", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stdp_pair_scheduler.md
Name: stdp_pair_scheduler

Overview:
- Sequences the combinational STDP weight-change datapath across a NUM_PRE x NUM_POST synapse array.
- On each accepted simulation timestep it timestamps pre/post spikes, then scans the affected synapse pairs.
- For each qualifying pair it drives t_change/apply into the datapath and hands the resulting dw to the weight store through a valid/ready port.

Parameters:
- NUM_PRE, 4, presynaptic neuron count.
- NUM_POST, 4, postsynaptic neuron count.
- N, 32, datapath word width (sign-magnitude, bit N-1 = sign).
- FRAC, 16, fractional bits of t_change/dw.
- TS_W, 8, timestamp counter width.
- WINDOW, 4, max |t_pre - t_post| in steps (used only with STDP_WINDOW_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- step  in  1  timestep strobe; accepted only when step_ready=1
- step_ready  out  1  high in IDLE
- pre_spike  in  NUM_PRE  spike vector, sampled with accepted step
- post_spike  in  NUM_POST  spike vector, sampled with accepted step
- t_change  out  N  to datapath; sign-magnitude, integer part at [N-2:FRAC]
- apply  out  1  to datapath
- dw_in  in  N  datapath result
- upd_valid  out  1  weight update offered
- upd_ready  in  1  weight store accepts
- upd_addr  out  clog2(NUM_PRE*NUM_POST)  i*NUM_POST + j
- upd_dw  out  N  captured dw
- done  out  1  one-cycle pulse when a scan completes
- overrun  out  1  sticky: step arrived while not ready

Behaviour:
- Reset: state IDLE; time_now=0; all stamp-valid bits=0; t_change=0, apply=0, upd_valid=0, upd_addr=0, upd_dw=0, done=0, overrun=0; step_ready=1 from the first cycle after reset. Reset mid-scan drops any pending update.
- Accepted step (step & step_ready):
  - Latch the spike vectors.
  - For each spiking neuron, set last_pre[i] or last_post[j] to time_now and set its valid bit.
  - Increment time_now (wraps mod 2^TS_W).
  - Next cycle: enter SCAN.
- Step while not ready: ignored, overrun<=1, time_now unchanged.
- Scan order:
  - Phase P (LTP): for each latched post j (ascending), all pre i (ascending).
  - Phase D (LTD): for each latched pre i, all post j.
  - Non-spiking outer indices are skipped at 0 cycles.
- Pair qualification:
  - Both stamps valid.
  - diff = last_pre[i] - last_post[j], computed mod 2^TS_W and interpreted as signed TS_W.
  - diff != 0.
- States:
  - SCAN (1 cycle/pair): qualifying pair -> ISSUE; otherwise advance; after the last pair -> IDLE with done=1.
  - ISSUE: t_change = {sign(diff), |diff| << FRAC}; apply=1.
  - CAPTURE: apply=1; upd_dw<=dw_in, upd_addr<=i*NUM_POST+j, upd_valid<=1 on the next cycle -> WAIT.
  - WAIT: hold upd_valid, upd_addr, upd_dw stable until upd_valid & upd_ready; then drop upd_valid, advance, return to SCAN.
- apply=0 outside ISSUE/CAPTURE. t_change holds its last value.
- Pair latency: 4 cycles minimum (SCAN, ISSUE, CAPTURE, WAIT with upd_ready=1).
- Simultaneous pre and post spike in one step give diff=0, so the pair is skipped in both phases.
- |diff| magnitude field saturates at its max if it does not fit in N-1-FRAC bits.

Optional Feature:
- Macro STDP_WINDOW_EN.
- Defined: pairs with |diff| > WINDOW fail qualification and are skipped.
- Undefined: the WINDOW parameter is unused; every valid nonzero pair is issued.

Test Plan:
- pre0 spikes at time_now=3, post0 at time_now=5 -> phase P issues t_change=0x80020000, apply high 2 cycles; upd_addr=0, upd_dw=dw_in sampled in CAPTURE; done pulses.
- post1 spikes at 2, pre2 at 3 -> phase D issues t_change=0x00010000; upd_addr=9.
- pre0 and post0 spike in the same step, no prior stamps -> no upd_valid; done after scan; t_change unchanged.
- upd_ready held low 5 cycles in WAIT -> upd_valid/upd_addr/upd_dw stable; no other pair issued; advance the cycle after upd_ready=1.
- step asserted during SCAN -> ignored; overrun=1 until reset; time_now unchanged; reset mid-WAIT -> upd_valid=0, step_ready=1 next cycle.
- WINDOW=4, pre at 250, post at 0 after wrap (TS_W=8, diff=-6) -> with STDP_WINDOW_EN skipped; without it issues t_change=0x80060000.
